// File: rtl/lut_arb_pkg.sv
// Shared types and helpers for the LUT ROM arbiter.
// Round-robin scan and pointer-advance functions live here.
package lut_arb_pkg;

    localparam int NREQ_MAX = 8;
    localparam int IDXW     = $clog2(NREQ_MAX);

    typedef struct packed {
        logic            valid;
        logic [IDXW-1:0] idx;
        logic            oob;
    } stage_t;

    // Scanning k downward lets the smallest offset from ptr win last.
    function automatic logic [IDXW:0] rr_pick(
        input logic [NREQ_MAX-1:0] mask,
        input logic [IDXW-1:0]     ptr,
        input int                  n
    );
        logic [IDXW:0] r;
        int j;
        r = '0;
        for (int k = NREQ_MAX - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % n;
            if (k < n && mask[j]) r = {1'b1, IDXW'(j)};
        end
        return r;
    endfunction

    function automatic logic [IDXW-1:0] ptr_next(
        input logic [IDXW-1:0] idx,
        input int              n
    );
        return IDXW'((int'(idx) + 1) % n);
    endfunction

endpackage

// File: rtl/lut_arb_rr_pick.sv
// Combinational two-winner round-robin picker.
// Port 1 winner is the next requester after port 0's in the same scan.
import lut_arb_pkg::*;

module lut_arb_rr_pick #(
    parameter int NREQ = 4
) (
    input  logic            i_en,
    input  logic [NREQ-1:0] i_valid,
    input  logic [IDXW-1:0] i_ptr,
    output logic            o_found0,
    output logic [IDXW-1:0] o_idx0,
    output logic            o_found1,
    output logic [IDXW-1:0] o_idx1,
    output logic [NREQ-1:0] o_ready
);

    logic [NREQ_MAX-1:0] w_mask;
    logic [NREQ_MAX-1:0] w_mask1;

    always_comb begin
        w_mask = '0;
        w_mask[NREQ-1:0] = i_valid;
        if (!i_en) w_mask = '0;
        {o_found0, o_idx0} = rr_pick(w_mask, i_ptr, NREQ);
        w_mask1 = w_mask;
        if (o_found0) w_mask1[o_idx0] = 1'b0;
        {o_found1, o_idx1} = rr_pick(w_mask1, i_ptr, NREQ);
        o_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            o_ready[i] = (o_found0 && o_idx0 == IDXW'(i))
                      || (o_found1 && o_idx1 == IDXW'(i));
        end
    end

endmodule

// File: rtl/lut_rom_arbiter.sv
// Shares a dual-port 1-cycle LUT ROM among NREQ requesters.
// Two grants per cycle; registered responses two cycles after grant.
import lut_arb_pkg::*;

module lut_rom_arbiter #(
    parameter int NREQ     = 4,
    parameter int AWIDTH   = 8,
    parameter int DWIDTH   = 36,
    parameter int MEM_SIZE = 197,
    parameter int CNTW     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*AWIDTH-1:0]   req_addr,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [NREQ*DWIDTH-1:0]   rsp_data,
    output logic [NREQ-1:0]          rsp_err,
    output logic [AWIDTH-1:0]        rom_addr0,
    output logic                     rom_ce0,
    input  logic [DWIDTH-1:0]        rom_q0,
    output logic [AWIDTH-1:0]        rom_addr1,
    output logic                     rom_ce1,
    input  logic [DWIDTH-1:0]        rom_q1,
    output logic [CNTW-1:0]          oob_count,
    output logic                     busy
);

    logic [IDXW-1:0]     r_rr;
    stage_t              r_s1_0;
    stage_t              r_s1_1;
    logic [NREQ-1:0]     r_rsp_valid;
    logic [NREQ*DWIDTH-1:0] r_rsp_data;
    logic [NREQ-1:0]     r_rsp_err;
    logic [CNTW-1:0]     r_oob_cnt;

    logic                w_f0;
    logic                w_f1;
    logic [IDXW-1:0]     w_i0;
    logic [IDXW-1:0]     w_i1;
    logic [AWIDTH-1:0]   w_addr0;
    logic [AWIDTH-1:0]   w_addr1;
    logic                w_oob0;
    logic                w_oob1;
    logic [CNTW:0]       w_cnt_sum;
    logic [CNTW-1:0]     w_cnt_next;

    lut_arb_rr_pick #(.NREQ(NREQ)) u_pick (
        .i_en     (reset),
        .i_valid  (req_valid),
        .i_ptr    (r_rr),
        .o_found0 (w_f0),
        .o_idx0   (w_i0),
        .o_found1 (w_f1),
        .o_idx1   (w_i1),
        .o_ready  (req_ready)
    );

    always_comb begin
        w_addr0 = '0;
        w_addr1 = '0;
        if (w_f0) w_addr0 = req_addr[int'(w_i0)*AWIDTH +: AWIDTH];
        if (w_f1) w_addr1 = req_addr[int'(w_i1)*AWIDTH +: AWIDTH];
        w_oob0 = w_f0 && (int'(w_addr0) >= MEM_SIZE);
        w_oob1 = w_f1 && (int'(w_addr1) >= MEM_SIZE);
        w_cnt_sum = {1'b0, r_oob_cnt} + (CNTW+1)'(w_oob0)
                  + (CNTW+1)'(w_oob1);
        w_cnt_next = w_cnt_sum[CNTW] ? '1 : w_cnt_sum[CNTW-1:0];
    end

    assign rom_addr0 = w_addr0;
    assign rom_addr1 = w_addr1;
    assign rom_ce0   = w_f0 && !w_oob0;
    assign rom_ce1   = w_f1 && !w_oob1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rr        <= '0;
            r_s1_0      <= '0;
            r_s1_1      <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= '0;
            r_oob_cnt   <= '0;
        end else begin
            if (w_f1)      r_rr <= ptr_next(w_i1, NREQ);
            else if (w_f0) r_rr <= ptr_next(w_i0, NREQ);
            r_s1_0      <= stage_t'{w_f0, w_i0, w_oob0};
            r_s1_1      <= stage_t'{w_f1, w_i1, w_oob1};
            r_oob_cnt   <= w_cnt_next;
            r_rsp_valid <= '0;
            // Ports never share a requester, so at most one write per slice.
            for (int i = 0; i < NREQ; i++) begin
                if (r_s1_0.valid && r_s1_0.idx == IDXW'(i)) begin
                    r_rsp_valid[i] <= 1'b1;
                    r_rsp_err[i]   <= r_s1_0.oob;
                    r_rsp_data[i*DWIDTH +: DWIDTH] <=
                        r_s1_0.oob ? '0 : rom_q0;
                end
                if (r_s1_1.valid && r_s1_1.idx == IDXW'(i)) begin
                    r_rsp_valid[i] <= 1'b1;
                    r_rsp_err[i]   <= r_s1_1.oob;
                    r_rsp_data[i*DWIDTH +: DWIDTH] <=
                        r_s1_1.oob ? '0 : rom_q1;
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign oob_count = r_oob_cnt;
    assign busy      = r_s1_0.valid | r_s1_1.valid | (|r_rsp_valid);

endmodule

// File: tb/tb_lut_rom_arbiter.sv
// Scoreboard bench for lut_rom_arbiter with a behavioural dual-port ROM.
// Stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_lut_rom_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int DW   = 36;
    localparam int MS   = 197;
    localparam int CW   = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ*DW-1:0] rsp_data;
    logic [NREQ-1:0]   rsp_err;
    logic [AW-1:0]     rom_addr0;
    logic              rom_ce0;
    logic [DW-1:0]     rom_q0 = '0;
    logic [AW-1:0]     rom_addr1;
    logic              rom_ce1;
    logic [DW-1:0]     rom_q1 = '0;
    logic [CW-1:0]     oob_count;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
        int            due;
    } exp_t;

    exp_t sb[NREQ][$];
    exp_t m_e;

    lut_rom_arbiter #(
        .NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW),
        .MEM_SIZE(MS), .CNTW(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rom_addr0(rom_addr0), .rom_ce0(rom_ce0), .rom_q0(rom_q0),
        .rom_addr1(rom_addr1), .rom_ce1(rom_ce1), .rom_q1(rom_q1),
        .oob_count(oob_count), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        if (a == 8'd5) return 36'h123456789;
        return {a, 20'hC0DE5, a};
    endfunction

    always @(posedge clk) begin
        if (rom_ce0) rom_q0 <= rom_word(rom_addr0);
        if (rom_ce1) rom_q1 <= rom_word(rom_addr1);
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic push(input int r, input logic [AW-1:0] a);
        exp_t e;
        e.e   = (int'(a) >= MS);
        e.d   = e.e ? '0 : rom_word(a);
        e.due = cyc + 2;
        sb[r].push_back(e);
    endtask

    task automatic set_addr(input int r, input logic [AW-1:0] a);
        req_addr[r*AW +: AW] = a;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        req_valid = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rsp_valid[i] === 1'b1) begin
                if (sb[i].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp req%0d cyc=%0d", i, cyc);
                end else begin
                    m_e = sb[i].pop_front();
                    chk($sformatf("rsp_data%0d", i),
                        64'(rsp_data[i*DW +: DW]), 64'(m_e.d));
                    chk($sformatf("rsp_err%0d", i),
                        64'(rsp_err[i]), 64'(m_e.e));
                    chk($sformatf("rsp_latency%0d", i),
                        64'(cyc), 64'(m_e.due));
                end
            end else if (sb[i].size() > 0 && sb[i][0].due < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL missing_rsp req%0d due=%0d now=%0d",
                         i, sb[i][0].due, cyc);
                void'(sb[i].pop_front());
            end
        end
    end

    initial begin
        int ep;
        int gcnt[NREQ];
        logic [NREQ-1:0] pat;
        req_valid = '0;
        req_addr  = '0;
        @(posedge clk);
        #2;

        // Grants and ROM enables are suppressed while reset is held.
        req_valid = '1;
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_ce0", 64'(rom_ce0), 64'h0);
        chk("rst_ce1", 64'(rom_ce1), 64'h0);
        step();
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_err", 64'(rsp_err), 64'h0);
        chk("rst_rsp_data0", 64'(rsp_data[DW-1:0]), 64'h0);
        chk("rst_oob", 64'(oob_count), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        req_valid = '0;
        reset = 1'b1;

        // Single request.
        set_addr(0, 8'd5);
        req_valid = 4'b0001;
        #1;
        chk("single_ready", 64'(req_ready), 64'h1);
        chk("single_ce0", 64'(rom_ce0), 64'h1);
        chk("single_addr0", 64'(rom_addr0), 64'd5);
        chk("single_ce1", 64'(rom_ce1), 64'h0);
        push(0, 8'd5);
        step();
        req_valid = '0;
        #1;
        chk("single_busy", 64'(busy), 64'h1);

        // All four requesting for three cycles.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_addr(i, AW'(10 + i));
        for (int c = 0; c < 3; c++) begin
            req_valid = 4'b1111;
            #1;
            pat = (c == 1) ? 4'b1100 : 4'b0011;
            chk($sformatf("all_ready_c%0d", c), 64'(req_ready), 64'(pat));
            chk($sformatf("all_addr0_c%0d", c), 64'(rom_addr0),
                (c == 1) ? 64'd12 : 64'd10);
            chk($sformatf("all_addr1_c%0d", c), 64'(rom_addr1),
                (c == 1) ? 64'd13 : 64'd11);
            for (int i = 0; i < NREQ; i++)
                if (pat[i]) push(i, AW'(10 + i));
            step();
        end
        req_valid = '0;

        // Out-of-range handling.
        do_reset();
        set_addr(2, 8'd200);
        req_valid = 4'b0100;
        #1;
        chk("oob_ready", 64'(req_ready), 64'h4);
        chk("oob_ce0", 64'(rom_ce0), 64'h0);
        chk("oob_ce1", 64'(rom_ce1), 64'h0);
        chk("oob_addr0", 64'(rom_addr0), 64'd200);
        push(2, 8'd200);
        step();
        req_valid = '0;
        #1;
        chk("oob_count1", 64'(oob_count), 64'd1);
        step();
        set_addr(1, 8'd7);
        set_addr(2, 8'd250);
        req_valid = 4'b0110;
        #1;
        chk("mix_ready", 64'(req_ready), 64'h6);
        chk("mix_ce0", 64'(rom_ce0), 64'h1);
        chk("mix_addr0", 64'(rom_addr0), 64'd7);
        chk("mix_ce1", 64'(rom_ce1), 64'h0);
        push(1, 8'd7);
        push(2, 8'd250);
        step();
        req_valid = '0;
        #1;
        chk("oob_count2", 64'(oob_count), 64'd2);

        // Drive the counter past its all-ones limit.
        for (int i = 0; i < NREQ; i++) set_addr(i, 8'd255);
        ep = 3;
        repeat (32768) begin
            req_valid = 4'b1111;
            push(ep, 8'd255);
            push((ep + 1) % NREQ, 8'd255);
            ep = (ep + 2) % NREQ;
            step();
        end
        req_valid = '0;
        repeat (3) step();
        chk("oob_sat", 64'(oob_count), 64'hFFFF);
        req_valid = 4'b0001;
        push(0, 8'd255);
        step();
        req_valid = '0;
        #1;
        chk("oob_sat_hold", 64'(oob_count), 64'hFFFF);

        // Fairness against a hog.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_addr(i, AW'(20 + i));
        req_valid = 4'b0001;
        #1;
        chk("hog_first", 64'(req_ready), 64'h1);
        push(0, 8'd20);
        step();
        req_valid = 4'b1001;
        #1;
        chk("hog_req3", 64'(req_ready), 64'h9);
        push(3, 8'd23);
        push(0, 8'd20);
        step();
        for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
        for (int c = 0; c < 100; c++) begin
            req_valid = 4'b1011;
            #1;
            pat = (c % 3 == 0) ? 4'b1010 :
                  (c % 3 == 1) ? 4'b0011 : 4'b1001;
            chk($sformatf("fair_ready_c%0d", c), 64'(req_ready), 64'(pat));
            for (int i = 0; i < NREQ; i++) begin
                gcnt[i] += int'(req_ready[i]);
                if (pat[i]) push(i, AW'(20 + i));
            end
            step();
        end
        req_valid = '0;
        chk("fair_cnt0", 64'(gcnt[0] >= 66 && gcnt[0] <= 68), 64'h1);
        chk("fair_cnt1", 64'(gcnt[1] >= 66 && gcnt[1] <= 68), 64'h1);
        chk("fair_cnt3", 64'(gcnt[3] >= 66 && gcnt[3] <= 68), 64'h1);
        repeat (3) step();

        // Reset while requests are in flight.
        set_addr(1, 8'd30);
        set_addr(2, 8'd200);
        req_valid = 4'b0110;
        #1;
        chk("mid_ready", 64'(req_ready), 64'h6);
        step();
        req_valid = '0;
        reset = 1'b0;
        #1;
        chk("mid_busy_before", 64'(busy), 64'h1);
        chk("mid_oob_before", 64'(oob_count), 64'd1);
        step();
        reset = 1'b1;
        #1;
        chk("mid_busy_after", 64'(busy), 64'h0);
        chk("mid_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("mid_oob_after", 64'(oob_count), 64'h0);
        for (int i = 0; i < NREQ; i++) set_addr(i, AW'(40 + i));
        req_valid = 4'b1111;
        #1;
        chk("mid_rr_zero", 64'(req_ready), 64'h3);
        push(0, 8'd40);
        push(1, 8'd41);
        step();
        req_valid = '0;

        // Idle cycles leave the pointer alone.
        for (int k = 0; k < 10; k++) begin
            step();
            if (k >= 1) begin
                chk($sformatf("idle_ce0_%0d", k), 64'(rom_ce0), 64'h0);
                chk($sformatf("idle_ce1_%0d", k), 64'(rom_ce1), 64'h0);
                chk($sformatf("idle_busy_%0d", k), 64'(busy), 64'h0);
                chk($sformatf("idle_rsp_%0d", k), 64'(rsp_valid), 64'h0);
            end
        end
        req_valid = 4'b1111;
        #1;
        chk("idle_rr_kept", 64'(req_ready), 64'hC);
        push(2, 8'd42);
        push(3, 8'd43);
        step();
        req_valid = '0;
        repeat (4) step();

        for (int i = 0; i < NREQ; i++)
            chk($sformatf("sb_empty%0d", i), 64'(sb[i].size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
